// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/move results plus a
// multi-cycle restoring divider for DIV/DIVU that stalls the pipeline.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq
);
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, DONE} div_state_t;

    div_state_t  state_reg;
    logic [5:0]  cnt_reg;
    logic [31:0] divisor_reg;
    logic [31:0] quo_reg;
    logic [31:0] rem_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;

    logic        is_div;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic [32:0] diff;

    assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign is_signed = (aluop_i == EXE_DIV_OP);
    assign abs_a     = (is_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign abs_b     = (is_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    // Partial remainder shifted left with the next dividend bit from quo_reg's MSB
    assign trial     = {rem_reg, quo_reg[31]};
    assign diff      = trial - {1'b0, divisor_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            divisor_reg <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_div) begin
                        if (reg2_i == 32'd0) begin
                            state_reg <= BY_ZERO;
                        end else begin
                            state_reg   <= ON;
                            cnt_reg     <= '0;
                            divisor_reg <= abs_b;
                            quo_reg     <= abs_a;
                            rem_reg     <= '0;
                            neg_q_reg   <= is_signed && (reg1_i[31] ^ reg2_i[31]);
                            neg_r_reg   <= is_signed && reg1_i[31];
                        end
                    end
                end
                BY_ZERO: begin
                    quo_reg   <= '0;
                    rem_reg   <= '0;
                    neg_q_reg <= 1'b0;
                    neg_r_reg <= 1'b0;
                    state_reg <= DONE;
                end
                ON: begin
                    if (!diff[32]) begin
                        rem_reg <= diff[31:0];
                        quo_reg <= {quo_reg[30:0], 1'b1};
                    end else begin
                        rem_reg <= trial[31:0];
                        quo_reg <= {quo_reg[30:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'(DIV_CYCLES - 1))
                        state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;
    logic [31:0] move_res;
    logic [4:0]  shamt;

    assign shamt = reg1_i[4:0];

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        move_res  = '0;
        case (aluop_i)
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << shamt;
            EXE_SRL_OP:  shift_res = reg2_i >> shamt;
            EXE_SRA_OP:  shift_res = $unsigned($signed(reg2_i) >>> shamt);
            EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
            EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
            EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
            EXE_MFHI_OP: move_res  = hi_i;
            EXE_MFLO_OP: move_res  = lo_i;
            default: ;
        endcase
    end

    always_comb begin
        wd_o     = wd_i;
        wreg_o   = wreg_i;
        wdata_o  = '0;
        whilo_o  = 1'b0;
        hi_o     = hi_i;
        lo_o     = lo_i;
        stallreq = 1'b0;
        case (alusel_i)
            EXE_RES_LOGIC: wdata_o = logic_res;
            EXE_RES_SHIFT: wdata_o = shift_res;
            EXE_RES_ARITH: wdata_o = arith_res;
            EXE_RES_MOVE:  wdata_o = move_res;
            default:       wdata_o = '0;
        endcase
        if (state_reg == DONE) begin
            whilo_o = 1'b1;
            lo_o    = neg_q_reg ? (~quo_reg + 32'd1) : quo_reg;
            hi_o    = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;
        end else if (aluop_i == EXE_MTHI_OP) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
        end else if (aluop_i == EXE_MTLO_OP) begin
            whilo_o = 1'b1;
            lo_o    = reg1_i;
        end
        stallreq = ((state_reg == IDLE) && is_div) || (state_reg == ON) || (state_reg == BY_ZERO);
        if (rst) begin
            wd_o     = '0;
            wreg_o   = 1'b0;
            wdata_o  = '0;
            whilo_o  = 1'b0;
            hi_o     = '0;
            lo_o     = '0;
            stallreq = 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, plus
// hand-written divide, divide-by-zero and reset-abort sequences.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o;
    logic        stallreq;

    int checks = 0;
    int passed = 0;

    localparam logic [7:0] AND_OP = 8'h24, OR_OP = 8'h25, XOR_OP = 8'h26, NOR_OP = 8'h27;
    localparam logic [7:0] SLL_OP = 8'h7C, SRL_OP = 8'h02, SRA_OP = 8'h03;
    localparam logic [7:0] SLT_OP = 8'h2A, SLTU_OP = 8'h2B, ADDU_OP = 8'h21, SUBU_OP = 8'h23;
    localparam logic [7:0] MFHI_OP = 8'h10, MTHI_OP = 8'h11, MFLO_OP = 8'h12, MTLO_OP = 8'h13;
    localparam logic [7:0] DIV_OP = 8'h1A, DIVU_OP = 8'h1B, NOP_OP = 8'h00;
    localparam logic [2:0] R_NOP = 3'd0, R_LOGIC = 3'd1, R_SHIFT = 3'd2, R_MOVE = 3'd3, R_ARITH = 3'd4;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b, hi, lo;
        logic [31:0] exp_wdata;
        logic        exp_whilo;
        logic [31:0] exp_hi, exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        @(negedge clk);
        aluop_i = op; alusel_i = R_NOP; reg1_i = a; reg2_i = b; wreg_i = 1'b0;
        #1;
        n = 0;
        while (stallreq === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check({name, "_whilo"}, {31'd0, whilo_o}, 32'd1);
        check({name, "_lo"}, lo_o, exp_lo);
        check({name, "_hi"}, hi_o, exp_hi);
        $display("div %s a=0x%08h b=0x%08h stall=%0d lo=0x%08h hi=0x%08h", name, a, b, n, lo_o, hi_o);
        @(negedge clk);
        aluop_i = NOP_OP;
        #1;
        check({name, "_idle_after"}, {30'd0, whilo_o, stallreq}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"or",   OR_OP,   R_LOGIC, 32'h0000F0F0, 32'h00FF0000, 0, 0, 32'h00FFF0F0, 0, 0, 0});
        vecs.push_back('{"and",  AND_OP,  R_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 32'h0F000F00, 0, 0, 0});
        vecs.push_back('{"xor",  XOR_OP,  R_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 32'hF0F00F0F, 0, 0, 0});
        vecs.push_back('{"nor",  NOR_OP,  R_LOGIC, 32'h0000FFFF, 32'h00FF0000, 0, 0, 32'hFF000000, 0, 0, 0});
        vecs.push_back('{"sll",  SLL_OP,  R_SHIFT, 32'd4,        32'h80000010, 0, 0, 32'h00000100, 0, 0, 0});
        vecs.push_back('{"sllm", SLL_OP,  R_SHIFT, 32'h24,       32'h00000001, 0, 0, 32'h00000010, 0, 0, 0});
        vecs.push_back('{"srl",  SRL_OP,  R_SHIFT, 32'd4,        32'h80000010, 0, 0, 32'h08000001, 0, 0, 0});
        vecs.push_back('{"sra",  SRA_OP,  R_SHIFT, 32'd4,        32'h80000010, 0, 0, 32'hF8000001, 0, 0, 0});
        vecs.push_back('{"addu", ADDU_OP, R_ARITH, 32'hFFFFFFFF, 32'd2,        0, 0, 32'h00000001, 0, 0, 0});
        vecs.push_back('{"subu", SUBU_OP, R_ARITH, 32'd1,        32'd2,        0, 0, 32'hFFFFFFFF, 0, 0, 0});
        vecs.push_back('{"slt",  SLT_OP,  R_ARITH, 32'hFFFFFFFF, 32'd1,        0, 0, 32'h00000001, 0, 0, 0});
        vecs.push_back('{"sltu", SLTU_OP, R_ARITH, 32'hFFFFFFFF, 32'd1,        0, 0, 32'h00000000, 0, 0, 0});
        vecs.push_back('{"mfhi", MFHI_OP, R_MOVE,  0, 0, 32'hAAAA5555, 32'h12345678, 32'hAAAA5555, 0, 0, 0});
        vecs.push_back('{"mflo", MFLO_OP, R_MOVE,  0, 0, 32'hAAAA5555, 32'h12345678, 32'h12345678, 0, 0, 0});
        vecs.push_back('{"mthi", MTHI_OP, R_NOP,   32'h1234, 0, 32'h77, 32'h5555, 32'h0, 1, 32'h1234, 32'h5555});
        vecs.push_back('{"mtlo", MTLO_OP, R_NOP,   32'hBEEF, 0, 32'h77, 32'h5555, 32'h0, 1, 32'h77,   32'hBEEF});
        vecs.push_back('{"nopsel", OR_OP, R_NOP,   32'hFFFF, 32'h1, 0, 0, 32'h0, 0, 0, 0});
        vecs.push_back('{"badsel", OR_OP, 3'd7,    32'hFFFF, 32'h1, 0, 0, 32'h0, 0, 0, 0});

        rst = 1'b1; aluop_i = OR_OP; alusel_i = R_LOGIC; reg1_i = 32'hF0F0; reg2_i = 32'h00FF0000;
        wd_i = 5'd5; wreg_i = 1'b1; hi_i = 32'h11; lo_i = 32'h22;
        @(negedge clk); @(negedge clk);
        #1;
        check("reset_wdata", wdata_o, 32'd0);
        check("reset_ctrl", {24'd0, wd_o, wreg_o, whilo_o, stallreq}, 32'd0);
        check("reset_hilo", hi_o | lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            aluop_i = vecs[i].op; alusel_i = vecs[i].sel; reg1_i = vecs[i].a; reg2_i = vecs[i].b;
            hi_i = vecs[i].hi; lo_i = vecs[i].lo; wd_i = 5'(i); wreg_i = i[0];
            #1;
            $display("vec %s a=0x%08h b=0x%08h wdata=0x%08h whilo=%0b hi=0x%08h lo=0x%08h",
                     vecs[i].name, vecs[i].a, vecs[i].b, wdata_o, whilo_o, hi_o, lo_o);
            check({vecs[i].name, "_wdata"}, wdata_o, vecs[i].exp_wdata);
            check({vecs[i].name, "_whilo_stall"}, {30'd0, whilo_o, stallreq}, {30'd0, vecs[i].exp_whilo, 1'b0});
            check({vecs[i].name, "_wd_wreg"}, {26'd0, wd_o, wreg_o}, {26'd0, 5'(i), i[0]});
            if (vecs[i].exp_whilo) begin
                check({vecs[i].name, "_hi"}, hi_o, vecs[i].exp_hi);
                check({vecs[i].name, "_lo"}, lo_o, vecs[i].exp_lo);
            end
        end

        hi_i = 32'hDEAD; lo_i = 32'hBEEF;
        run_div("divu_100_7",  DIVU_OP, 32'd100,       32'd7,        33, 32'd14,        32'd2);
        run_div("div_m7_2",    DIV_OP,  32'hFFFFFFF9,  32'd2,        33, 32'hFFFFFFFD,  32'hFFFFFFFF);
        run_div("div_wrap",    DIV_OP,  32'h80000000,  32'hFFFFFFFF, 33, 32'h80000000,  32'h0);
        run_div("divu_big",    DIVU_OP, 32'hFFFFFFFF,  32'h10,       33, 32'h0FFFFFFF,  32'hF);
        run_div("div_7_m2",    DIV_OP,  32'd7,         32'hFFFFFFFE, 33, 32'hFFFFFFFD,  32'd1);
        run_div("div_by_zero", DIV_OP,  32'd5,         32'd0,        2,  32'd0,         32'd0);

        // Abort a DIVU at iteration 10 with reset, then confirm nothing is written.
        begin
            int bad;
            @(negedge clk);
            aluop_i = DIVU_OP; alusel_i = R_NOP; reg1_i = 32'd100; reg2_i = 32'd7;
            repeat (11) @(negedge clk);
            #1;
            check("abort_stalling", {31'd0, stallreq}, 32'd1);
            rst = 1'b1; aluop_i = NOP_OP;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("abort_stall_released", {31'd0, stallreq}, 32'd0);
            bad = 0;
            repeat (40) begin
                @(negedge clk);
                #1;
                if (whilo_o !== 1'b0 || stallreq !== 1'b0) bad++;
            end
            check("abort_no_hilo_write", 32'(bad), 32'd0);
            $display("abort after reset: bad_cycles=%0d", bad);
            aluop_i = MTHI_OP; reg1_i = 32'h1234; lo_i = 32'h9999;
            #1;
            check("abort_mthi_hi", hi_o, 32'h1234);
            check("abort_mthi_lo_whilo", {lo_o[30:0], whilo_o}, {31'h9999, 1'b1});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
